// File: rtl/montgomery_mult.sv
// Word-serial CIOS Montgomery multiplier: result = a*b*R^-1 mod n, R = 2^WIDTH.
// Optional operand checking is built when MONT_OPERAND_CHECK_EN is defined.
module montgomery_mult #(
    parameter int WIDTH = 2048,
    parameter int WORD  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    input  logic [WORD-1:0]  n0prime,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int NW = WIDTH / WORD;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    // Headroom so the ACC sum t + a_i*b never wraps; after RED t < 2n again.
    localparam int TW = WIDTH + WORD + 2;

    typedef enum logic [1:0] {IDLE, ACC, RED, FIN} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_reg, b_reg, n_reg, result_reg;
    logic [WORD-1:0]    n0p_reg;
    logic [TW-1:0]      t_reg;
    logic [IW-1:0]      i_reg;
    logic               done_reg;

    logic [WORD-1:0]    a_words [NW];
    logic [WORD-1:0]    a_word;
    logic [WORD-1:0]    m;
    logic [TW-1:0]      acc_sum, red_sum, fin_val;
    logic               accept, last_iter, zero_res;

    genvar gi;
    generate
        for (gi = 0; gi < NW; gi++) begin : g_words
            assign a_words[gi] = a_reg[gi*WORD +: WORD];
        end
    endgenerate

    // A start in the done cycle is ignored: the pulse marks the tail of the previous op.
    assign accept    = (state_reg == IDLE) && start && !done_reg;
    assign last_iter = (i_reg == IW'(NW - 1));
    assign a_word    = a_words[i_reg];
    assign m         = t_reg[WORD-1:0] * n0p_reg;
    assign acc_sum   = t_reg + TW'(a_word) * TW'(b_reg);
    assign red_sum   = t_reg + TW'(m) * TW'(n_reg);
    assign fin_val   = (t_reg >= TW'(n_reg)) ? (t_reg - TW'(n_reg)) : t_reg;

    assign result = result_reg;
    assign done   = done_reg;
    assign busy   = (state_reg == ACC) || (state_reg == RED);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = ACC;
            ACC:     state_next = RED;
            RED:     state_next = last_iter ? FIN : ACC;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            n_reg      <= '0;
            n0p_reg    <= '0;
            t_reg      <= '0;
            i_reg      <= '0;
            result_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        n_reg   <= n;
                        n0p_reg <= n0prime;
                        t_reg   <= '0;
                        i_reg   <= '0;
                    end
                end
                ACC: t_reg <= acc_sum;
                RED: begin
                    // Low WORD bits of red_sum are zero by choice of m.
                    t_reg <= red_sum >> WORD;
                    i_reg <= i_reg + 1'b1;
                end
                FIN: begin
                    result_reg <= zero_res ? '0 : WIDTH'(fin_val);
                    done_reg   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MONT_OPERAND_CHECK_EN
    logic chk_reg, err_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_reg <= 1'b0;
            err_reg <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            if (accept)
                chk_reg <= !n[0] || (a >= n) || (b >= n);
            if (state_reg == FIN)
                err_reg <= chk_reg;
        end
    end

    assign zero_res = chk_reg;
    assign err      = err_reg;
`else
    assign zero_res = 1'b0;
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_montgomery_mult.sv
// Directed bench for montgomery_mult at WIDTH=64, WORD=32, n = 2^64-59.
module tb_montgomery_mult;

    localparam int WIDTH = 64;
    localparam int WORD  = 32;
    localparam logic [63:0] NMOD = 64'hFFFF_FFFF_FFFF_FFC5;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a, b, n;
    logic [WORD-1:0]  n0prime;
    logic [WIDTH-1:0] result;
    logic             busy, done, err;

    int checks = 0;
    int errors = 0;

    montgomery_mult #(.WIDTH(WIDTH), .WORD(WORD)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .n(n),
        .n0prime(n0prime), .result(result), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        bit          use_model;
    } vec_t;

    vec_t vecs [10];

    // Binary (bit-at-a-time) Montgomery reduction of a*b mod m.
    function automatic logic [63:0] mont_ref(logic [63:0] x, logic [63:0] y, logic [63:0] md);
        logic [127:0] p;
        logic [64:0]  r;
        p = {64'd0, x} * {64'd0, y};
        p = p % {64'd0, md};
        r = {1'b0, p[63:0]};
        for (int k = 0; k < 64; k++) begin
            if (r[0]) r = r + {1'b0, md};
            r = r >> 1;
        end
        return r[63:0];
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, got, exp);
        end
    endtask

    task automatic launch(input logic [63:0] av, input logic [63:0] bv, input logic [63:0] nv);
        @(negedge clk);
        a = av; b = bv; n = nv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int edges, output int bcnt);
        edges = 0;
        bcnt  = 0;
        while (!done && edges < 60) begin
            if (busy) bcnt++;
            @(negedge clk);
            edges++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: no done after %0d edges, want done", edges);
        end
    endtask

    task automatic do_op(input string nm, input logic [63:0] av, input logic [63:0] bv,
                         input logic [63:0] nv, input logic [63:0] exp, input logic exp_err);
        int edges, bcnt;
        launch(av, bv, nv);
        wait_done(edges, bcnt);
        $display("op %s a=%h b=%h n=%h result=%h err=%0b edges=%0d", nm, av, bv, nv, result, err, edges);
        check({nm, " result"}, result, exp);
        check({nm, " latency"}, 64'(edges), 64'd5);
        check({nm, " busy_cycles"}, 64'(bcnt), 64'd4);
        check({nm, " err"}, 64'(err), 64'(exp_err));
    endtask

    initial begin
        logic [31:0] inv;
        logic [63:0] exp;
        int edges, bcnt, ndone;

        reset = 1'b1; start = 1'b0; a = '0; b = '0; n = NMOD;
        inv = 32'd59;
        for (int k = 0; k < 5; k++) inv = inv * (32'd2 - 32'd59 * inv);
        n0prime = inv;

        vecs[0] = '{a: 64'd1,     b: 64'd3481,   exp: 64'd59,   use_model: 1'b0};
        vecs[1] = '{a: 64'd59,    b: 64'd1,      exp: 64'd1,    use_model: 1'b0};
        vecs[2] = '{a: 64'd3481,  b: 64'd1,      exp: 64'd59,   use_model: 1'b0};
        vecs[3] = '{a: 64'd59,    b: 64'd59,     exp: 64'd59,   use_model: 1'b0};
        vecs[4] = '{a: 64'd118,   b: 64'd59,     exp: 64'd118,  use_model: 1'b0};
        vecs[5] = '{a: 64'd59,    b: NMOD-64'd1, exp: NMOD-64'd1, use_model: 1'b0};
        vecs[6] = '{a: NMOD-64'd1, b: NMOD-64'd1, exp: 64'd0,   use_model: 1'b1};
        vecs[7] = '{a: 64'd0,     b: NMOD-64'd1, exp: 64'd0,    use_model: 1'b0};
        vecs[8] = '{a: NMOD-64'd1, b: 64'd0,     exp: 64'd0,    use_model: 1'b0};
        vecs[9] = '{a: 64'h0123_4567_89AB_CDEF, b: 64'hFEDC_BA98_7654_3210, exp: 64'd0, use_model: 1'b1};

        #12;
        check("reset result", result, 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset err", 64'(err), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table vectors, issued back-to-back (start in the cycle after each done).
        for (int i = 0; i < 10; i++) begin
            exp = vecs[i].use_model ? mont_ref(vecs[i].a, vecs[i].b, NMOD) : vecs[i].exp;
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, NMOD, exp, 1'b0);
        end
        @(negedge clk);
        check("done pulse width", 64'(done), 64'd0);

        // Start while busy: second request with different operands must be ignored.
        launch(64'd1, 64'd3481, NMOD);
        @(negedge clk);
        a = 64'd59; b = 64'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(edges, bcnt);
        $display("op busy_start result=%h edges=%0d", result, edges + 2);
        check("busy_start latency", 64'(edges + 2), 64'd5);
        check("busy_start result", result, 64'd59);

        // Start raised during the done cycle must be ignored.
        a = 64'd59; b = 64'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_cycle_start busy", 64'(busy), 64'd0);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        $display("op done_cycle_start extra_dones=%0d result=%h", ndone, result);
        check("done_cycle_start dones", 64'(ndone), 64'd0);
        check("done_cycle_start held", result, 64'd59);

        do_op("b2b_0", 64'd59, 64'd1, NMOD, 64'd1, 1'b0);
        do_op("b2b_1", 64'd3481, 64'd1, NMOD, 64'd59, 1'b0);

        // Reset three cycles into an operation aborts it without a done pulse.
        launch(64'd1, 64'd3481, NMOD);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort result", result, 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        $display("op abort extra_dones=%0d", ndone);
        check("abort no_done", 64'(ndone), 64'd0);
        do_op("after_abort", 64'd59, 64'd59, NMOD, 64'd59, 1'b0);

`ifdef MONT_OPERAND_CHECK_EN
        do_op("even_n", 64'd1, 64'd1, NMOD + 64'd1, 64'd0, 1'b1);
        do_op("after_err", 64'd59, 64'd1, NMOD, 64'd1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
